// File: rtl/adapt_fir_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// adapt_fir_mem_port_arbiter
//
// Shares port 2 of the 512x32 adaptive-FIR coefficient/sample RAM between two
// Avalon-MM masters. M0 is the FIR tap/sample sequencer. M1 is the LMS
// coefficient updater.
//
// The block grants at most one access per cycle. It uses round-robin selection
// and limits one master to MAX_HOLD consecutive grants while the other master
// is waiting. Read data is returned with a fixed latency of one cycle.
//
// Ports
//   clk, reset_n            clock and asynchronous active-low reset
//   mN_address/read/write   Avalon-MM command from master N (N = 0, 1)
//   mN_writedata/byteenable write payload from master N
//   mN_waitrequest          stall to master N; the master holds its command
//   mN_readdata/valid       read response to master N, one cycle after grant
//   ram_*                   RAM port-2 command; ram_readdata is its q output
//   ram_clken               RAM clock enable, tied high
//   grant_owner             debug: 00 none, 01 M0, 10 M1 for the current cycle
// ---------------------------------------------------------------------------
module adapt_fir_mem_port_arbiter #(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 32,
    parameter int BE_W     = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic [BE_W-1:0]   m0_byteenable,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic [BE_W-1:0]   m1_byteenable,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    output logic [BE_W-1:0]   ram_byteenable,
    input  logic [DATA_W-1:0] ram_readdata,
    output logic              ram_clken,
    output logic [1:0]        grant_owner
);

    typedef enum logic [1:0] {
        SEL_NONE = 2'b00,
        SEL_M0   = 2'b01,
        SEL_M1   = 2'b10
    } sel_e;

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

    sel_e             last_owner, next_owner, sel, other;
    logic [7:0]       hold_cnt, next_cnt;
    logic             req0, req1, last_req, other_req;
    logic             rv0, rv1;
    logic [ADDR_W-1:0] addr_q, cmd_addr;
    logic [DATA_W-1:0] wdata_q, cmd_wdata;
    logic [BE_W-1:0]   be_q, cmd_be;

    // Selection and next-state logic. hold_cnt==0 means no master was granted
    // on the previous cycle. In that case last_owner is not continuing a run,
    // so the other master gets first choice. This gives M0 the win on
    // simultaneous first requests after reset, because last_owner resets to M1.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave a value unassigned and infer a latch.
        sel        = SEL_NONE;
        next_owner = last_owner;
        next_cnt   = hold_cnt;
        req0       = m0_read | m0_write;
        req1       = m1_read | m1_write;
        last_req   = (last_owner == SEL_M0) ? req0 : req1;
        other_req  = (last_owner == SEL_M0) ? req1 : req0;
        other      = (last_owner == SEL_M0) ? SEL_M1 : SEL_M0;

        if (last_req && (hold_cnt != 8'd0) && ((hold_cnt < MAX_HOLD_C) || !other_req))
            sel = last_owner;
        else if (other_req)
            sel = other;
        else if (last_req)
            sel = last_owner;

        if (sel == SEL_NONE) begin
            next_cnt = 8'd0;
        end else if (sel == last_owner) begin
            next_cnt = (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;
        end else begin
            next_owner = sel;
            next_cnt   = 8'd1;
        end
    end

    // Command mux. If a master asserts read and write together, the write wins.
    always_comb begin
        cmd_addr  = (sel == SEL_M1) ? m1_address    : m0_address;
        cmd_wdata = (sel == SEL_M1) ? m1_writedata  : m0_writedata;
        cmd_be    = (sel == SEL_M1) ? m1_byteenable : m0_byteenable;
    end

    assign ram_chipselect = (sel != SEL_NONE);
    assign ram_write      = ((sel == SEL_M0) & m0_write) | ((sel == SEL_M1) & m1_write);
    assign ram_address    = ram_chipselect ? cmd_addr  : addr_q;
    assign ram_writedata  = ram_chipselect ? cmd_wdata : wdata_q;
    assign ram_byteenable = ram_chipselect ? cmd_be    : be_q;
    assign ram_clken      = 1'b1;
    assign grant_owner    = sel;

    assign m0_waitrequest   = req0 & (sel != SEL_M0);
    assign m1_waitrequest   = req1 & (sel != SEL_M1);
    assign m0_readdatavalid = rv0;
    assign m1_readdatavalid = rv1;
    assign m0_readdata      = rv0 ? ram_readdata : '0;
    assign m1_readdata      = rv1 ? ram_readdata : '0;

    // NOTE: sequential state uses non-blocking assignments. All registers
    // update together on the edge, regardless of the order of the statements.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_owner <= SEL_M1;
            hold_cnt   <= 8'd0;
            rv0        <= 1'b0;
            rv1        <= 1'b0;
        end else begin
            last_owner <= next_owner;
            hold_cnt   <= next_cnt;
            rv0        <= (sel == SEL_M0) & m0_read & ~m0_write;
            rv1        <= (sel == SEL_M1) & m1_read & ~m1_write;
        end
    end

    // Last issued command. It keeps ram_address, ram_writedata and
    // ram_byteenable stable while no master is selected.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (ram_chipselect) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            be_q    <= cmd_be;
        end
    end

    a_m0_no_rw: assert property (@(posedge clk) disable iff (!reset_n) !(m0_read && m0_write));
    a_m1_no_rw: assert property (@(posedge clk) disable iff (!reset_n) !(m1_read && m1_write));

endmodule

// File: tb/tb_adapt_fir_mem_port_arbiter.sv
module tb_adapt_fir_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [8:0]  m0_address, m1_address, ram_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata, ram_writedata;
    logic [3:0]  m0_byteenable, m1_byteenable, ram_byteenable;
    logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic [31:0] m0_readdata, m1_readdata, ram_readdata;
    logic        ram_chipselect, ram_write, ram_clken;
    logic [1:0]  grant_owner;

    // Second instance built with MAX_HOLD=1
    logic [8:0]  h_m0_address, h_m1_address, h_ram_address;
    logic        h_m0_read, h_m0_write, h_m1_read, h_m1_write;
    logic [31:0] h_m0_writedata, h_m1_writedata, h_ram_writedata;
    logic [3:0]  h_m0_byteenable, h_m1_byteenable, h_ram_byteenable;
    logic        h_m0_waitrequest, h_m1_waitrequest, h_m0_readdatavalid, h_m1_readdatavalid;
    logic [31:0] h_m0_readdata, h_m1_readdata, h_ram_readdata;
    logic        h_ram_chipselect, h_ram_write, h_ram_clken;
    logic [1:0]  h_grant_owner;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    adapt_fir_mem_port_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .ram_address(ram_address), .ram_chipselect(ram_chipselect),
        .ram_write(ram_write), .ram_writedata(ram_writedata),
        .ram_byteenable(ram_byteenable), .ram_readdata(ram_readdata),
        .ram_clken(ram_clken), .grant_owner(grant_owner)
    );

    adapt_fir_mem_port_arbiter #(.MAX_HOLD(1)) dut_h1 (
        .clk(clk), .reset_n(reset_n),
        .m0_address(h_m0_address), .m0_read(h_m0_read), .m0_write(h_m0_write),
        .m0_writedata(h_m0_writedata), .m0_byteenable(h_m0_byteenable),
        .m0_waitrequest(h_m0_waitrequest), .m0_readdata(h_m0_readdata),
        .m0_readdatavalid(h_m0_readdatavalid),
        .m1_address(h_m1_address), .m1_read(h_m1_read), .m1_write(h_m1_write),
        .m1_writedata(h_m1_writedata), .m1_byteenable(h_m1_byteenable),
        .m1_waitrequest(h_m1_waitrequest), .m1_readdata(h_m1_readdata),
        .m1_readdatavalid(h_m1_readdatavalid),
        .ram_address(h_ram_address), .ram_chipselect(h_ram_chipselect),
        .ram_write(h_ram_write), .ram_writedata(h_ram_writedata),
        .ram_byteenable(h_ram_byteenable), .ram_readdata(h_ram_readdata),
        .ram_clken(h_ram_clken), .grant_owner(h_grant_owner)
    );

    // RAM port-2 model: synchronous read, byte-enabled write. Every word is
    // preloaded with 0xA5A5_0000 | address.
    logic [31:0] mem [0:511];
    always @(posedge clk) begin
        if (ram_chipselect) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++)
                    if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
            end else begin
                ram_readdata <= mem[ram_address];
            end
        end
    end

    task automatic idle_inputs;
        m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = '0;
        m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = '0;
        h_m0_address = '0; h_m0_read = 0; h_m0_write = 0; h_m0_writedata = '0; h_m0_byteenable = '0;
        h_m1_address = '0; h_m1_read = 0; h_m1_write = 0; h_m1_writedata = '0; h_m1_byteenable = '0;
    endtask

    // Ends #1 after a rising edge with reset released; this is where stimulus is driven.
    task automatic apply_reset;
        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset_n = 1'b0;
        @(negedge clk);
        checks++; if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin errors++;
            $display("FAIL reset_valids got %b%b exp 00", m0_readdatavalid, m1_readdatavalid); end
        checks++; if (ram_chipselect !== 1'b0 || ram_write !== 1'b0) begin errors++;
            $display("FAIL reset_cs got cs=%b wr=%b exp 0 0", ram_chipselect, ram_write); end
        checks++; if (grant_owner !== 2'b00) begin errors++;
            $display("FAIL reset_grant got %b exp 00", grant_owner); end
        checks++; if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b0) begin errors++;
            $display("FAIL reset_wait got %b%b exp 00", m0_waitrequest, m1_waitrequest); end
        checks++; if (ram_address !== 9'h000 || ram_clken !== 1'b1) begin errors++;
            $display("FAIL reset_addr got addr=%h clken=%b exp 000 1", ram_address, ram_clken); end
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_single_read;
        apply_reset();
        m0_read = 1; m0_address = 9'h005;
        @(negedge clk);
        checks++; if (m0_waitrequest !== 1'b0 || grant_owner !== 2'b01 || ram_chipselect !== 1'b1) begin errors++;
            $display("FAIL single_grant got wait=%b grant=%b cs=%b exp 0 01 1", m0_waitrequest, grant_owner, ram_chipselect); end
        checks++; if (ram_address !== 9'h005) begin errors++;
            $display("FAIL single_addr got %h exp 005", ram_address); end
        @(posedge clk); #1 m0_read = 0; m0_address = 9'h0AA;
        @(negedge clk);
        checks++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hA5A5_0005) begin errors++;
            $display("FAIL single_data got v=%b d=%h exp 1 a5a50005", m0_readdatavalid, m0_readdata); end
        checks++; if (ram_chipselect !== 1'b0 || ram_address !== 9'h005 || grant_owner !== 2'b00) begin errors++;
            $display("FAIL single_idle_hold got cs=%b addr=%h grant=%b exp 0 005 00", ram_chipselect, ram_address, grant_owner); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (m0_readdatavalid !== 1'b0 || m0_readdata !== 32'h0) begin errors++;
            $display("FAIL single_no_dup got v=%b d=%h exp 0 0", m0_readdatavalid, m0_readdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin;
        logic [8:0] a0, a1, pa0, pa1;
        logic       p0, p1;
        logic [1:0] exp_g;
        int         v0, v1;
        apply_reset();
        a0 = 9'h010; a1 = 9'h100; pa0 = '0; pa1 = '0; p0 = 0; p1 = 0; v0 = 0; v1 = 0;
        m0_read = 1; m1_read = 1; m0_address = a0; m1_address = a1;
        for (int k = 0; k < 32; k++) begin
            exp_g = (((k / 8) % 2) == 0) ? 2'b01 : 2'b10;
            @(negedge clk);
            checks++; if (grant_owner !== exp_g) begin errors++;
                $display("FAIL rr_grant cycle %0d got %b exp %b", k, grant_owner, exp_g); end
            checks++; if (m0_waitrequest !== (exp_g != 2'b01) || m1_waitrequest !== (exp_g != 2'b10)) begin errors++;
                $display("FAIL rr_wait cycle %0d got %b%b", k, m0_waitrequest, m1_waitrequest); end
            checks++; if (m0_readdatavalid !== p0 || m1_readdatavalid !== p1) begin errors++;
                $display("FAIL rr_valid cycle %0d got %b%b exp %b%b", k, m0_readdatavalid, m1_readdatavalid, p0, p1); end
            if (p0) begin checks++; if (m0_readdata !== (32'hA5A5_0000 | 32'(pa0))) begin errors++;
                $display("FAIL rr_data0 cycle %0d got %h exp addr %h", k, m0_readdata, pa0); end end
            if (p1) begin checks++; if (m1_readdata !== (32'hA5A5_0000 | 32'(pa1))) begin errors++;
                $display("FAIL rr_data1 cycle %0d got %h exp addr %h", k, m1_readdata, pa1); end end
            if (m0_readdatavalid === 1'b1) v0++;
            if (m1_readdatavalid === 1'b1) v1++;
            @(posedge clk); #1;
            p0 = (exp_g == 2'b01); p1 = (exp_g == 2'b10);
            pa0 = a0; pa1 = a1;
            if (p0) a0 = a0 + 9'd1;
            if (p1) a1 = a1 + 9'd1;
            m0_address = a0; m1_address = a1;
        end
        m0_read = 0; m1_read = 0;
        @(negedge clk);
        checks++; if (m1_readdatavalid !== 1'b1 || m1_readdata !== (32'hA5A5_0000 | 32'(pa1))) begin errors++;
            $display("FAIL rr_drain got v=%b d=%h", m1_readdatavalid, m1_readdata); end
        if (m0_readdatavalid === 1'b1) v0++;
        if (m1_readdatavalid === 1'b1) v1++;
        checks++; if (v0 != 16 || v1 != 16) begin errors++;
            $display("FAIL rr_count got %0d/%0d exp 16/16", v0, v1); end
        @(posedge clk); #1;
    endtask

    task automatic test_m1_stream;
        apply_reset();
        for (int k = 0; k <= 20; k++) begin
            m1_read = (k < 20); m1_address = 9'(k);
            @(negedge clk);
            if (k < 20) begin
                checks++; if (grant_owner !== 2'b10 || m1_waitrequest !== 1'b0) begin errors++;
                    $display("FAIL stream_grant read %0d got grant=%b wait=%b exp 10 0", k, grant_owner, m1_waitrequest); end
            end
            checks++; if (m1_readdatavalid !== (k > 0)) begin errors++;
                $display("FAIL stream_valid cycle %0d got %b", k, m1_readdatavalid); end
            if (k > 0) begin checks++; if (m1_readdata !== (32'hA5A5_0000 | 32'(k - 1))) begin errors++;
                $display("FAIL stream_data cycle %0d got %h exp addr %0d", k, m1_readdata, k - 1); end end
            @(posedge clk); #1;
        end
        m1_read = 0;
    endtask

    task automatic test_write_read;
        apply_reset();
        m0_write = 1; m0_address = 9'h1FF; m0_writedata = 32'hDEAD_BEEF; m0_byteenable = 4'b0011;
        @(negedge clk);
        checks++; if (ram_write !== 1'b1 || ram_chipselect !== 1'b1 || m0_waitrequest !== 1'b0) begin errors++;
            $display("FAIL wr_cmd got wr=%b cs=%b wait=%b exp 1 1 0", ram_write, ram_chipselect, m0_waitrequest); end
        checks++; if (ram_address !== 9'h1FF || ram_writedata !== 32'hDEAD_BEEF || ram_byteenable !== 4'b0011) begin errors++;
            $display("FAIL wr_payload got %h %h %b", ram_address, ram_writedata, ram_byteenable); end
        @(posedge clk); #1 m0_write = 0; m0_read = 1; m0_byteenable = 4'b1111;
        @(negedge clk);
        checks++; if (m0_readdatavalid !== 1'b0 || ram_write !== 1'b0) begin errors++;
            $display("FAIL wr_no_resp got v=%b wr=%b exp 0 0", m0_readdatavalid, ram_write); end
        @(posedge clk); #1 m0_read = 0;
        @(negedge clk);
        checks++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hA5A5_BEEF) begin errors++;
            $display("FAIL wr_readback got v=%b d=%h exp 1 a5a5beef", m0_readdatavalid, m0_readdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_read;
        apply_reset();
        m1_read = 1; m1_address = 9'h003;
        @(negedge clk);
        checks++; if (grant_owner !== 2'b10) begin errors++;
            $display("FAIL midrst_grant got %b exp 10", grant_owner); end
        #1 reset_n = 1'b0; m1_read = 0;
        #1;
        checks++; if (m1_readdatavalid !== 1'b0 || ram_address !== 9'h000) begin errors++;
            $display("FAIL midrst_in_reset got v=%b addr=%h exp 0 000", m1_readdatavalid, ram_address); end
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        checks++; if (m1_readdatavalid !== 1'b0 || m1_readdata !== 32'h0) begin errors++;
            $display("FAIL midrst_dropped got v=%b d=%h exp 0 0", m1_readdatavalid, m1_readdata); end
        @(posedge clk); #1 m0_read = 1; m1_read = 1;
        @(negedge clk);
        checks++; if (grant_owner !== 2'b01 || m1_waitrequest !== 1'b1) begin errors++;
            $display("FAIL midrst_contest got grant=%b wait1=%b exp 01 1", grant_owner, m1_waitrequest); end
        @(posedge clk); #1 m0_read = 0; m1_read = 0;
    endtask

    task automatic test_max_hold_one;
        logic [1:0] exp_g;
        apply_reset();
        h_m0_read = 1; h_m1_read = 1; h_m0_address = 9'h020; h_m1_address = 9'h040;
        for (int k = 0; k < 8; k++) begin
            exp_g = ((k % 2) == 0) ? 2'b01 : 2'b10;
            @(negedge clk);
            checks++; if (h_grant_owner !== exp_g || h_m0_waitrequest !== (exp_g != 2'b01)) begin errors++;
                $display("FAIL hold1_alt cycle %0d got grant=%b wait0=%b exp %b", k, h_grant_owner, h_m0_waitrequest, exp_g); end
            @(posedge clk); #1;
        end
        h_m0_read = 0; h_m1_read = 0;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
        ram_readdata = '0;
        h_ram_readdata = '0;
        idle_inputs();
        reset_n = 1'b0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_m1_stream();
        test_write_read();
        test_reset_mid_read();
        test_max_hold_one();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
